// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences FETCH/DECODE/EXEC/MEM/WB over a shared memory, IR and ALU.
// Moore controls are registered alongside the state; FETCH IR/PC loads, pc_en and watchdog gating follow inputs in-cycle; memory states stall on mem_ready.
module mips_multicycle_ctrl #(
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             pc_en,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic [3:0]       state,
  output logic             halted,
  output logic             illegal_op,
  output logic             bus_err,
  output logic [CNT_W-1:0] instr_count
);

  localparam int WD_W = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEMADR  = 4'd3,
    S_MEMRD   = 4'd4,
    S_MEMWB   = 4'd5,
    S_MEMWR   = 4'd6,
    S_EXEC    = 4'd7,
    S_RWB     = 4'd8,
    S_BRANCH  = 4'd9,
    S_JUMP    = 4'd10,
    S_ADDI_EX = 4'd11,
    S_ADDI_WB = 4'd12,
    S_HALT    = 4'd15
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

  state_t           state_q;
  state_t           state_n;
  ctrl_t            ctrl_q;
  logic [WD_W-1:0]  wd_cnt;
  logic             in_fetch;
  logic             wd_expire;
  state_t           end_state;

  function automatic logic is_mem_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

  function automatic ctrl_t decode_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = 2'b01;
      end
      S_DECODE:  c.alu_src_b = 2'b11;
      S_MEMADR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      S_MEMWB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
      end
      S_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'b10;
      end
      S_RWB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_op        = 2'b01;
        c.pc_write_cond = 1'b1;
        c.pc_source     = 2'b01;
      end
      S_JUMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = 2'b10;
      end
      S_ADDI_EX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      S_ADDI_WB: c.reg_write = 1'b1;
      default:   c = '0;
    endcase
    return c;
  endfunction

  assign in_fetch  = (state_q == S_FETCH);
  assign wd_expire = is_mem_state(state_q) && !mem_ready && (wd_cnt == WD_W'(WAIT_MAX));
  assign end_state = run ? S_FETCH : S_IDLE;

  always_comb begin
    state_n = state_q;
    case (state_q)
      S_IDLE:   if (run) state_n = S_FETCH;
      S_FETCH: begin
        if (mem_ready)      state_n = S_DECODE;
        else if (wd_expire) state_n = S_HALT;
      end
      S_DECODE: begin
        case (opcode)
          OP_RTYPE: state_n = S_EXEC;
          OP_LW,
          OP_SW:    state_n = S_MEMADR;
          OP_BEQ:   state_n = S_BRANCH;
          OP_J:     state_n = S_JUMP;
          OP_ADDI:  state_n = S_ADDI_EX;
          default:  state_n = S_HALT;
        endcase
      end
      S_MEMADR: state_n = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD: begin
        if (mem_ready)      state_n = S_MEMWB;
        else if (wd_expire) state_n = S_HALT;
      end
      S_MEMWR: begin
        if (mem_ready)      state_n = end_state;
        else if (wd_expire) state_n = S_HALT;
      end
      S_EXEC:    state_n = S_RWB;
      S_ADDI_EX: state_n = S_ADDI_WB;
      S_MEMWB,
      S_RWB,
      S_BRANCH,
      S_JUMP,
      S_ADDI_WB: state_n = end_state;
      S_HALT:    state_n = S_HALT;
      default:   state_n = S_HALT;
    endcase
  end

  // Controls are loaded from the next state so they line up with state_q without a decode stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ctrl_q      <= '0;
      wd_cnt      <= '0;
      instr_count <= '0;
      illegal_op  <= 1'b0;
      bus_err     <= 1'b0;
    end else begin
      state_q <= state_n;
      ctrl_q  <= decode_ctrl(state_n);
      // A memory state only repeats itself while waiting, so any other transition is a fresh entry.
      if (is_mem_state(state_n) && (state_n == state_q))
        wd_cnt <= wd_cnt + 1'b1;
      else
        wd_cnt <= '0;
      if (in_fetch && mem_ready)
        instr_count <= instr_count + 1'b1;
      if ((state_q == S_DECODE) && (state_n == S_HALT))
        illegal_op <= 1'b1;
      if (wd_expire)
        bus_err <= 1'b1;
    end
  end

  assign PCWrite     = ctrl_q.pc_write | (in_fetch & mem_ready);
  assign IRWrite     = in_fetch & mem_ready;
  assign PCWriteCond = ctrl_q.pc_write_cond;
  assign pc_en       = PCWrite | (PCWriteCond & zero);
  assign IorD        = ctrl_q.iord;
  assign MemRead     = ctrl_q.mem_read & ~wd_expire;
  assign MemWrite    = ctrl_q.mem_write & ~wd_expire;
  assign MemtoReg    = ctrl_q.mem_to_reg;
  assign RegDst      = ctrl_q.reg_dst;
  assign RegWrite    = ctrl_q.reg_write;
  assign ALUSrcA     = ctrl_q.alu_src_a;
  assign ALUSrcB     = ctrl_q.alu_src_b;
  assign ALUOp       = ctrl_q.alu_op;
  assign PCSource    = ctrl_q.pc_source;
  assign state       = state_q;
  assign halted      = (state_q == S_HALT);

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: directed vector table, instruction-level random model, and watchdog/trap/reset sequences.
module tb_mips_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic [5:0]  opcode;
  logic        zero;
  logic        mem_ready;
  logic        PCWrite, PCWriteCond, pc_en, IorD, MemRead, MemWrite, IRWrite;
  logic        MemtoReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0]  ALUSrcB, ALUOp, PCSource;
  logic [3:0]  state;
  logic        halted, illegal_op, bus_err;
  logic [31:0] instr_count;

  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_cnt = 0;
  bit          exp_ill = 0;
  bit          exp_bus = 0;

  localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] BEQ = 6'b000100, J = 6'b000010, ADDI = 6'b001000;

  mips_multicycle_ctrl #(.WAIT_MAX(15), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .pc_en(pc_en), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg),
    .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .PCSource(PCSource), .state(state), .halted(halted),
    .illegal_op(illegal_op), .bus_err(bus_err), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [16:0] dut_vec();
    return {PCWrite, PCWriteCond, pc_en, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
            RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource};
  endfunction

  // Control values per step, straight from the step descriptions.
  function automatic logic [16:0] exp_vec(input int st, input bit rdy, input bit z, input bit expire);
    logic pcw, pcwc, iord, mr, mw, irw, m2r, rdst, rw, asa;
    logic [1:0] asb, aop, psrc;
    {pcw, pcwc, iord, mr, mw, irw, m2r, rdst, rw, asa} = '0;
    asb = 2'b00; aop = 2'b00; psrc = 2'b00;
    case (st)
      1:  begin mr = 1; asb = 2'b01; irw = rdy; pcw = rdy; end
      2:  asb = 2'b11;
      3:  begin asa = 1; asb = 2'b10; end
      4:  begin mr = 1; iord = 1; end
      5:  begin rw = 1; m2r = 1; end
      6:  begin mw = 1; iord = 1; end
      7:  begin asa = 1; aop = 2'b10; end
      8:  begin rw = 1; rdst = 1; end
      9:  begin asa = 1; aop = 2'b01; pcwc = 1; psrc = 2'b01; end
      10: begin pcw = 1; psrc = 2'b10; end
      11: begin asa = 1; asb = 2'b10; end
      12: rw = 1;
      default: ;
    endcase
    if (expire) {pcw, pcwc, mr, mw, irw, rw} = '0;
    return {pcw, pcwc, pcw | (pcwc & z), iord, mr, mw, irw, m2r, rdst, rw, asa, asb, aop, psrc};
  endfunction

  function automatic bit legal(input logic [5:0] op);
    return op inside {R, LW, SW, BEQ, J, ADDI};
  endfunction

  // One clock: drive at posedge+1, check at negedge, then advance the bench model.
  task automatic cycle(input int st, input bit rdy, input bit r, input bit expire);
    bit z;
    z = 1'($urandom_range(0, 1));
    mem_ready = rdy; zero = z; run = r;
    @(negedge clk);
    chk($sformatf("state(st%0d)", st), 32'(state), 32'(st));
    chk($sformatf("ctrl(st%0d rdy%0d z%0d)", st, rdy, z), 32'(dut_vec()), 32'(exp_vec(st, rdy, z, expire)));
    chk($sformatf("flags(st%0d)", st), {29'd0, halted, illegal_op, bus_err}, {29'd0, st == 15, exp_ill, exp_bus});
    chk($sformatf("instr_count(st%0d)", st), instr_count, exp_cnt);
    @(posedge clk); #1;
    if (st == 1 && rdy) exp_cnt++;
    if (expire) exp_bus = 1;
    if (st == 2 && !legal(opcode)) exp_ill = 1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_cnt = 0; exp_ill = 0; exp_bus = 0;
  endtask

  // Drives one whole legal instruction from FETCH; mode 0 random run, 1 run held, 2 run dropped after DECODE.
  task automatic run_instr(input logic [5:0] op, input int fw, input int mw, input int mode);
    int sts[$];
    int idx;
    bit r;
    opcode = op;
    case (op)
      R:       sts = '{2, 7, 8};
      LW:      sts = '{2, 3, 4, 5};
      SW:      sts = '{2, 3, 6};
      BEQ:     sts = '{2, 9};
      J:       sts = '{2, 10};
      default: sts = '{2, 11, 12};
    endcase
    sts.push_front(1);
    r = 1;
    foreach (sts[i]) begin
      int waits;
      waits = (sts[i] == 1) ? fw : ((sts[i] == 4 || sts[i] == 6) ? mw : 0);
      idx = i;
      for (int k = 0; k <= waits; k++) begin
        bit rdy;
        rdy = (sts[i] == 1 || sts[i] == 4 || sts[i] == 6) ? (k == waits) : 1'($urandom_range(0, 1));
        r = (mode == 0) ? 1'($urandom_range(0, 1)) : ((mode == 1) ? 1'b1 : (idx < 2));
        cycle(sts[i], rdy, r, 0);
      end
    end
    if (!r) cycle(0, 1'($urandom_range(0, 1)), 1, 0);
  endtask

  typedef struct {
    bit         run;
    logic [5:0] op;
    bit         rdy;
    bit         z;
    int         st;
    bit         rw;
    bit         rdst;
    bit         mr;
    bit         pcen;
    logic [1:0] aop;
  } vec_t;

  function automatic vec_t row(input bit r, input logic [5:0] op, input bit rdy, input bit z,
                               input int st, input bit rw, input bit rdst, input bit mr,
                               input bit pcen, input logic [1:0] aop);
    vec_t v;
    v.run = r; v.op = op; v.rdy = rdy; v.z = z; v.st = st;
    v.rw = rw; v.rdst = rdst; v.mr = mr; v.pcen = pcen; v.aop = aop;
    return v;
  endfunction

  initial begin
    vec_t tbl[$];
    logic [5:0] ops [6];
    ops = '{R, LW, SW, BEQ, J, ADDI};
    rst_n = 0; run = 0; opcode = 0; zero = 0; mem_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    //               run op   rdy z  st rw rd mr pe aop
    tbl.push_back(row(0, R,   0, 0, 0, 0, 0, 0, 0, 2'b00));
    tbl.push_back(row(1, R,   1, 0, 0, 0, 0, 0, 0, 2'b00));
    tbl.push_back(row(1, R,   1, 0, 1, 0, 0, 1, 1, 2'b00));
    tbl.push_back(row(1, R,   1, 0, 2, 0, 0, 0, 0, 2'b00));
    tbl.push_back(row(1, R,   1, 0, 7, 0, 0, 0, 0, 2'b10));
    tbl.push_back(row(1, R,   1, 0, 8, 1, 1, 0, 0, 2'b00));
    tbl.push_back(row(1, BEQ, 1, 0, 1, 0, 0, 1, 1, 2'b00));
    tbl.push_back(row(1, BEQ, 1, 1, 2, 0, 0, 0, 0, 2'b00));
    tbl.push_back(row(1, BEQ, 1, 1, 9, 0, 0, 0, 1, 2'b01));
    tbl.push_back(row(1, BEQ, 1, 0, 1, 0, 0, 1, 1, 2'b00));
    tbl.push_back(row(1, BEQ, 1, 0, 2, 0, 0, 0, 0, 2'b00));
    tbl.push_back(row(1, BEQ, 1, 0, 9, 0, 0, 0, 0, 2'b01));
    tbl.push_back(row(0, R,   1, 0, 1, 0, 0, 1, 1, 2'b00));
    tbl.push_back(row(0, R,   1, 0, 2, 0, 0, 0, 0, 2'b00));
    tbl.push_back(row(0, R,   1, 0, 7, 0, 0, 0, 0, 2'b10));
    tbl.push_back(row(0, R,   1, 0, 8, 1, 1, 0, 0, 2'b00));
    tbl.push_back(row(0, R,   1, 0, 0, 0, 0, 0, 0, 2'b00));
    tbl.push_back(row(1, R,   1, 0, 0, 0, 0, 0, 0, 2'b00));

    foreach (tbl[i]) begin
      run = tbl[i].run; opcode = tbl[i].op; mem_ready = tbl[i].rdy; zero = tbl[i].z;
      @(negedge clk);
      chk($sformatf("tbl%0d state", i), 32'(state), 32'(tbl[i].st));
      chk($sformatf("tbl%0d regwrite/regdst/memread", i), {29'd0, RegWrite, RegDst, MemRead},
          {29'd0, tbl[i].rw, tbl[i].rdst, tbl[i].mr});
      chk($sformatf("tbl%0d pc_en/aluop", i), {29'd0, pc_en, ALUOp}, {29'd0, tbl[i].pcen, tbl[i].aop});
      chk($sformatf("tbl%0d flags/count", i), {instr_count[28:0], halted, illegal_op, bus_err},
          {exp_cnt[28:0], 3'b000});
      @(posedge clk); #1;
      if (tbl[i].st == 1 && tbl[i].rdy) exp_cnt++;
    end

    // Random legal instruction stream with short memory waits and run toggling.
    for (int n = 0; n < 60; n++)
      run_instr(ops[$urandom_range(0, 5)], $urandom_range(0, 3), $urandom_range(0, 3), 0);

    run_instr(LW, 0, 3, 1);
    run_instr(SW, 1, 2, 2);

    // Reset while FETCH is waiting on memory.
    opcode = R;
    cycle(1, 0, 1, 0);
    cycle(1, 0, 1, 0);
    do_reset();
    cycle(0, 0, 0, 0);

    // FETCH watchdog expiry.
    cycle(0, 0, 1, 0);
    for (int k = 0; k < 15; k++) cycle(1, 0, 1'($urandom_range(0, 1)), 0);
    cycle(1, 0, 1, 1);
    for (int k = 0; k < 3; k++) cycle(15, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
    do_reset();

    // Ready arriving on the last allowed FETCH cycle wins.
    cycle(0, 0, 1, 0);
    run_instr(R, 15, 0, 1);

    // MEMWR watchdog expiry with MemWrite held through the wait.
    opcode = SW;
    cycle(1, 1, 1, 0);
    cycle(2, 0, 1, 0);
    cycle(3, 1, 1, 0);
    for (int k = 0; k < 15; k++) cycle(6, 0, 1'($urandom_range(0, 1)), 0);
    cycle(6, 0, 1, 1);
    cycle(15, 1, 1, 0);
    do_reset();

    // Illegal opcode trap, sticky through run toggling, cleared by reset.
    cycle(0, 0, 1, 0);
    opcode = 6'b111111;
    cycle(1, 1, 1, 0);
    cycle(2, 0, 1, 0);
    for (int k = 0; k < 4; k++) cycle(15, 1'($urandom_range(0, 1)), k[0], 0);
    do_reset();
    cycle(0, 0, 0, 0);
    cycle(0, 0, 1, 0);
    run_instr(ADDI, 0, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
